// File: rtl/moment_ram_reader.sv
// Raster-order scanner for a moment RAM: streams every cell out with x/y tags over valid/ready
// and keeps a signed running sum of the accepted beats for a mass-conservation check.
module moment_ram_reader #(
   parameter int GRID_W        = 16,
   parameter int GRID_H        = 16,
   parameter int DEPTH         = GRID_W * GRID_H,
   parameter int ADDRESS_WIDTH = $clog2(DEPTH),
   parameter int DATA_WIDTH    = 32
) (
   input  logic                                      Clk,
   input  logic                                      Reset_n,
   input  logic                                      start,
   input  logic                                      abort,
   output logic [ADDRESS_WIDTH-1:0]                  ram_addr,
   input  logic signed [DATA_WIDTH-1:0]              ram_data,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   output logic signed [DATA_WIDTH-1:0]              out_data,
   output logic [$clog2(GRID_W)-1:0]                 out_x,
   output logic [$clog2(GRID_H)-1:0]                 out_y,
   output logic                                      out_last,
   output logic                                      busy,
   output logic                                      done,
   output logic signed [DATA_WIDTH+ADDRESS_WIDTH-1:0] sum,
   output logic [1:0]                                dbg_state
);

   // Handshake: a beat transfers on any rising edge where out_valid && out_ready; once
   // out_valid rises, out_data/out_x/out_y/out_last stay frozen until that transfer.

   localparam int XW = $clog2(GRID_W);
   localparam int YW = $clog2(GRID_H);
   localparam int SW = DATA_WIDTH + ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
   localparam logic [XW-1:0]            X_LAST    = XW'(GRID_W - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            load;
   logic            accept;
   logic [XW-1:0]   x_cnt;
   logic [YW-1:0]   y_cnt;

   assign load      = !out_valid || out_ready;
   assign accept    = out_valid && out_ready;
   assign busy      = (state != S_IDLE);
   assign dbg_state = state;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start && !abort) state_nxt = S_SCAN;
         end
         S_SCAN: begin
            if (abort)                                state_nxt = S_IDLE;
            else if (load && ram_addr == LAST_ADDR)   state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (abort)       state_nxt = S_IDLE;
            else if (accept) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         ram_addr  <= '0;
         x_cnt     <= '0;
         y_cnt     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_x     <= '0;
         out_y     <= '0;
         out_last  <= 1'b0;
         done      <= 1'b0;
         sum       <= '0;
      end else begin
         done <= 1'b0;
         // A beat accepted on an abort edge still counts toward the partial sum.
         if (accept) sum <= sum + $signed({{ADDRESS_WIDTH{out_data[DATA_WIDTH-1]}}, out_data});
         case (state)
            S_IDLE: begin
               ram_addr <= '0;
               x_cnt    <= '0;
               y_cnt    <= '0;
               if (start && !abort) sum <= '0;
            end
            S_SCAN: begin
               if (abort) begin
                  out_valid <= 1'b0;
                  ram_addr  <= '0;
                  x_cnt     <= '0;
                  y_cnt     <= '0;
               end else if (load) begin
                  out_data  <= ram_data;
                  out_x     <= x_cnt;
                  out_y     <= y_cnt;
                  out_last  <= (ram_addr == LAST_ADDR);
                  out_valid <= 1'b1;
                  // The address parks on the final cell for the whole drain phase.
                  if (ram_addr != LAST_ADDR) begin
                     ram_addr <= ram_addr + ADDRESS_WIDTH'(1);
                     if (x_cnt == X_LAST) begin
                        x_cnt <= '0;
                        y_cnt <= y_cnt + YW'(1);
                     end else begin
                        x_cnt <= x_cnt + XW'(1);
                     end
                  end
               end
            end
            S_DRAIN: begin
               if (abort) begin
                  out_valid <= 1'b0;
                  ram_addr  <= '0;
                  x_cnt     <= '0;
                  y_cnt     <= '0;
               end else if (accept) begin
                  out_valid <= 1'b0;
                  done      <= 1'b1;
                  ram_addr  <= '0;
                  x_cnt     <= '0;
                  y_cnt     <= '0;
               end
            end
            default: begin
               out_valid <= 1'b0;
               ram_addr  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_moment_ram_reader.sv
// Bench for moment_ram_reader: a RAM array feeds the scanner and each scenario task compares
// the streamed beats, timing and sum against a cell-index model of the expected sweep.
module tb_moment_ram_reader;

   localparam int W     = 16;
   localparam int H     = 16;
   localparam int DEPTH = W * H;
   localparam int AW    = 8;
   localparam int DW    = 32;
   localparam int PW    = 1 + 4 + 4 + DW;

   logic                  Clk;
   logic                  Reset_n;
   logic                  start;
   logic                  abort;
   logic [AW-1:0]         ram_addr;
   logic signed [DW-1:0]  ram_data;
   logic                  out_valid;
   logic                  out_ready;
   logic signed [DW-1:0]  out_data;
   logic [3:0]            out_x;
   logic [3:0]            out_y;
   logic                  out_last;
   logic                  busy;
   logic                  done;
   logic signed [DW+AW-1:0] sum;
   logic [1:0]            dbg_state;

   logic signed [DW-1:0]  mem [0:DEPTH-1];
   logic [PW-1:0]         exp_q[$];
   logic [PW-1:0]         got_q[$];
   int                    total;
   int                    bad;

   moment_ram_reader #(
      .GRID_W(W), .GRID_H(H), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .start(start), .abort(abort),
      .ram_addr(ram_addr), .ram_data(ram_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_x(out_x), .out_y(out_y), .out_last(out_last),
      .busy(busy), .done(done), .sum(sum), .dbg_state(dbg_state)
   );

   assign ram_data = mem[ram_addr];

   // clock / reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [PW-1:0] payload();
      return {out_last, out_y, out_x, out_data};
   endfunction

   // reference model: the cell at raster index i carries x=i%W, y=i/W, last only at DEPTH-1
   function automatic logic [PW-1:0] model_beat(input int i);
      logic [3:0] x;
      logic [3:0] y;
      x = 4'(i % W);
      y = 4'(i / W);
      return {(i == DEPTH - 1), y, x, mem[i]};
   endfunction

   function automatic longint model_sum(input int n);
      longint s;
      s = 0;
      for (int i = 0; i < n; i++) s += longint'(mem[i]);
      return s;
   endfunction

   task automatic build_expected();
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) exp_q.push_back(model_beat(i));
   endtask

   task automatic fill_index();
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
   endtask

   task automatic fill_const(input logic signed [DW-1:0] v);
      for (int i = 0; i < DEPTH; i++) mem[i] = v;
   endtask

   // driver: issues start, then plays out_ready/start noise and records accepted beats
   task automatic run_sweep(input int ready_pct, input int start_pct,
                            output int done_cyc, output int stall_errs);
      logic [PW-1:0] prev;
      bit            stalled;
      got_q.delete();
      stall_errs = 0;
      done_cyc   = -1;
      stalled    = 1'b0;
      prev       = '0;
      start      = 1'b1;
      out_ready  = 1'b0;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5000; k++) begin
         if (stalled && (!out_valid || payload() !== prev)) stall_errs++;
         if (done) begin
            done_cyc = k;
            break;
         end
         out_ready = (int'($urandom_range(99)) < ready_pct);
         start     = (int'($urandom_range(99)) < start_pct);
         if (out_valid && out_ready) got_q.push_back(payload());
         stalled = out_valid && !out_ready;
         prev    = payload();
         tick();
      end
      start     = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      int dc;
      Reset_n = 1'b0;
      #2;
      total++;
      if ({out_valid, out_last, busy, done} !== 4'b0 || out_data !== '0 || sum !== '0 ||
          ram_addr !== '0 || {out_x, out_y} !== 8'h0 || dbg_state !== 2'd0) begin
         bad++;
         $display("FAIL reset_initial: valid=%0b busy=%0b data=%0d sum=%0d addr=%0d state=%0d expected all 0",
                  out_valid, busy, out_data, sum, ram_addr, dbg_state);
      end
      tick();
      Reset_n = 1'b1;
      tick();
      fill_index();
      start = 1'b1;
      tick();
      start     = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 20; k++) tick();
      total++;
      if (dbg_state !== 2'd1 || !out_valid) begin
         bad++;
         $display("FAIL reset_pre_scan: state=%0d valid=%0b expected state 1 valid 1", dbg_state, out_valid);
      end
      #2;
      Reset_n = 1'b0;
      #1;
      total++;
      if ({out_valid, out_last, busy, done} !== 4'b0 || out_data !== '0 || sum !== '0 ||
          ram_addr !== '0 || {out_x, out_y} !== 8'h0 || dbg_state !== 2'd0) begin
         bad++;
         $display("FAIL reset_mid_scan: valid=%0b busy=%0b data=%0d x=%0d y=%0d sum=%0d addr=%0d state=%0d expected all 0",
                  out_valid, busy, out_data, out_x, out_y, sum, ram_addr, dbg_state);
      end
      out_ready = 1'b0;
      tick();
      Reset_n = 1'b1;
      tick();
      dc = 0;
      for (int k = 0; k < 4; k++) begin
         if (out_valid || busy) dc++;
         tick();
      end
      total++;
      if (dc != 0) begin
         bad++;
         $display("FAIL reset_stays_idle: active cycles=%0d expected 0", dc);
      end
   endtask

   task automatic test_full_sweep();
      int dc;
      int se;
      int errs;
      fill_index();
      build_expected();
      run_sweep(100, 0, dc, se);
      total++;
      if (dc != DEPTH + 1) begin
         bad++;
         $display("FAIL full_done_latency: got %0d cycles expected %0d", dc, DEPTH + 1);
      end
      total++;
      if (got_q.size() != DEPTH) begin
         bad++;
         $display("FAIL full_beat_count: got %0d expected %0d", got_q.size(), DEPTH);
      end
      errs = 0;
      for (int i = 0; i < DEPTH && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin
            bad++;
            errs++;
            if (errs < 5) $display("FAIL full_beat[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
         end
      end
      total++;
      if (longint'(sum) != model_sum(DEPTH)) begin
         bad++;
         $display("FAIL full_sum: got %0d expected %0d", sum, model_sum(DEPTH));
      end
      total++;
      if (busy || out_valid || ram_addr !== '0 || dbg_state !== 2'd0) begin
         bad++;
         $display("FAIL full_idle_at_done: busy=%0b valid=%0b addr=%0d state=%0d expected 0 0 0 0",
                  busy, out_valid, ram_addr, dbg_state);
      end
      tick();
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL full_done_pulse_width: got done=%0b expected 0", done);
      end
   endtask

   task automatic test_backpressure();
      int dc;
      int se;
      int errs;
      fill_index();
      build_expected();
      run_sweep(30, 0, dc, se);
      total++;
      if (dc < 0) begin
         bad++;
         $display("FAIL bp_done_seen: got timeout expected done");
      end
      total++;
      if (se != 0) begin
         bad++;
         $display("FAIL bp_stall_stability: got %0d unstable stalls expected 0", se);
      end
      total++;
      if (got_q.size() != DEPTH) begin
         bad++;
         $display("FAIL bp_beat_count: got %0d expected %0d", got_q.size(), DEPTH);
      end
      errs = 0;
      for (int i = 0; i < DEPTH && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin
            bad++;
            errs++;
            if (errs < 5) $display("FAIL bp_beat[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
         end
      end
      total++;
      if (longint'(sum) != model_sum(DEPTH)) begin
         bad++;
         $display("FAIL bp_sum: got %0d expected %0d", sum, model_sum(DEPTH));
      end
      tick();
   endtask

   task automatic test_signed();
      int dc;
      int se;
      int errs;
      fill_const(32'sh8000_0000);
      build_expected();
      run_sweep(80, 0, dc, se);
      total++;
      if (got_q.size() != DEPTH || se != 0) begin
         bad++;
         $display("FAIL signed_beats: got count=%0d stalls=%0d expected %0d 0", got_q.size(), se, DEPTH);
      end
      errs = 0;
      for (int i = 0; i < DEPTH && i < got_q.size(); i++) begin
         if (got_q[i] !== exp_q[i]) errs++;
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL signed_beat_values: got %0d wrong beats expected 0", errs);
      end
      total++;
      if (longint'(sum) != model_sum(DEPTH)) begin
         bad++;
         $display("FAIL signed_sum: got %0d expected %0d", sum, model_sum(DEPTH));
      end
      tick();
   endtask

   task automatic test_abort();
      int           acc;
      longint       exp_sum;
      int           dones;
      int           dc;
      int           se;
      int           errs;
      fill_const(32'sd1);
      acc   = 0;
      start = 1'b1;
      tick();
      start     = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 100 && acc < 10; k++) begin
         if (out_valid) acc++;
         tick();
      end
      abort     = 1'b1;
      out_ready = 1'b1;
      exp_sum   = longint'(acc) + (out_valid ? 1 : 0);
      tick();
      abort     = 1'b0;
      out_ready = 1'b0;
      total++;
      if (dbg_state !== 2'd0 || out_valid || busy || done || ram_addr !== '0) begin
         bad++;
         $display("FAIL abort_to_idle: state=%0d valid=%0b busy=%0b done=%0b addr=%0d expected 0 0 0 0 0",
                  dbg_state, out_valid, busy, done, ram_addr);
      end
      total++;
      if (longint'(sum) != exp_sum) begin
         bad++;
         $display("FAIL abort_partial_sum: got %0d expected %0d", sum, exp_sum);
      end
      dones = 0;
      for (int k = 0; k < 6; k++) begin
         if (done) dones++;
         tick();
      end
      total++;
      if (dones != 0 || longint'(sum) != exp_sum) begin
         bad++;
         $display("FAIL abort_quiet: got done pulses=%0d sum=%0d expected 0 and %0d", dones, sum, exp_sum);
      end
      fill_index();
      build_expected();
      run_sweep(100, 0, dc, se);
      errs = 0;
      for (int i = 0; i < DEPTH && i < got_q.size(); i++) begin
         if (got_q[i] !== exp_q[i]) errs++;
      end
      total++;
      if (got_q.size() != DEPTH || errs != 0 || dc != DEPTH + 1) begin
         bad++;
         $display("FAIL abort_resweep: got count=%0d wrong=%0d latency=%0d expected %0d 0 %0d",
                  got_q.size(), errs, dc, DEPTH, DEPTH + 1);
      end
      total++;
      if (longint'(sum) != model_sum(DEPTH)) begin
         bad++;
         $display("FAIL abort_resweep_sum: got %0d expected %0d", sum, model_sum(DEPTH));
      end
      tick();
   endtask

   task automatic test_start_ignored();
      int dc;
      int se;
      int errs;
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      total++;
      if (dbg_state !== 2'd0 || busy || out_valid) begin
         bad++;
         $display("FAIL start_abort_idle: state=%0d busy=%0b valid=%0b expected 0 0 0", dbg_state, busy, out_valid);
      end
      tick();
      fill_index();
      build_expected();
      run_sweep(100, 25, dc, se);
      errs = 0;
      for (int i = 0; i < DEPTH && i < got_q.size(); i++) begin
         if (got_q[i] !== exp_q[i]) errs++;
      end
      total++;
      if (got_q.size() != DEPTH || errs != 0) begin
         bad++;
         $display("FAIL start_busy_beats: got count=%0d wrong=%0d expected %0d 0", got_q.size(), errs, DEPTH);
      end
      total++;
      if (dc != DEPTH + 1) begin
         bad++;
         $display("FAIL start_busy_latency: got %0d expected %0d", dc, DEPTH + 1);
      end
      total++;
      if (longint'(sum) != model_sum(DEPTH)) begin
         bad++;
         $display("FAIL start_busy_sum: got %0d expected %0d", sum, model_sum(DEPTH));
      end
      tick();
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      Reset_n   = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      out_ready = 1'b0;
      fill_index();
      test_reset();
      test_full_sweep();
      test_backpressure();
      test_signed();
      test_abort();
      test_start_ignored();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
